pipe_stage_elastic: RTL

// - Generic, parametrised inter-stage pipeline register for the MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush and NOP-bubble forcing of control fields.
// - Each stage instantiates it with its own data and control payload widths.
// - Sustains 1 transfer/cycle under backpressure with a registered o_ready.

---
 rtl/pipe_pkg.sv | 63 ++++++
 rtl/pipe_stat_counter.sv | 24 ++
 rtl/pipe_stage_elastic.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline inter-stage registers.
// Holds the stage FSM encoding, per-stage payload widths, packed control
// groups (EX/M/WB) and the NOP control constants that make a bubble inert.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // Per-stage payload widths used when instantiating pipe_stage_elastic.
    localparam int IFID_DATA_W  = 64;   // pc + instruction
    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_DATA_W  = 128;  // pc, rs/rt values, imm, reg indices
    localparam int IDEX_CTRL_W  = 24;
    localparam int EXMEM_DATA_W = 96;
    localparam int EXMEM_CTRL_W = 16;
    localparam int MEMWB_DATA_W = 80;
    localparam int MEMWB_CTRL_W = 8;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       jump;
    } ex_ctrl_t;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] size;
        logic       sign_ext;
        logic [2:0] rsvd;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_wr;
        logic       mem_to_reg;
        logic       link;
        logic [4:0] rsvd;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } idex_ctrl_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } exmem_ctrl_t;

    // All-zero control never writes registers or memory.
    localparam ex_ctrl_t    EX_CTRL_NOP    = '0;
    localparam mem_ctrl_t   MEM_CTRL_NOP   = '0;
    localparam wb_ctrl_t    WB_CTRL_NOP    = '0;
    localparam idex_ctrl_t  IDEX_CTRL_NOP  = '{EX_CTRL_NOP, MEM_CTRL_NOP, WB_CTRL_NOP};
    localparam exmem_ctrl_t EXMEM_CTRL_NOP = '{MEM_CTRL_NOP, WB_CTRL_NOP};

endpackage

// File: rtl/pipe_stat_counter.sv
// Saturating event counter.
// Ports: i_clk, i_reset_n (async, active low), i_en (count this cycle),
//        o_cnt (current value, sticks at all-ones).
module pipe_stat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_cnt <= '0;
        else if (i_en && (r_cnt != {W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with a 2-entry skid buffer.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
// Ports:
//   i_clk, i_reset_n (async, active low), i_flush (sync, discards everything)
//   upstream:   i_valid, o_ready (registered), i_data, i_ctrl
//   downstream: o_valid, i_ready, o_data, o_ctrl (CTRL_NOP when empty)
//   stats:      o_stall_cnt, o_flush_cnt (PIPE_STAGE_STATS_EN only)
// All outputs come straight from registers; no input reaches an output
// combinationally.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 128,
    parameter int                CTRL_W   = 24,
    parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}},
    parameter int                STAT_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0] o_stall_cnt,
    output logic [STAT_W-1:0] o_flush_cnt
`endif
);

    pipe_state_e       r_state, w_state_nxt;
    logic              r_ready;
    logic [DATA_W-1:0] r_main_data, r_skid_data;
    logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;

    logic w_in_fire, w_out_fire;
    logic w_main_from_in, w_main_from_skid, w_skid_from_in;

    assign w_in_fire  = i_valid & r_ready;
    assign w_out_fire = (r_state != EMPTY) & i_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (i_flush) begin
            // Flush wins over any transfer; an accepted input is dropped too.
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt    = ONE;
                        w_main_from_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_from_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt    = TWO;
                        w_skid_from_in = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt    = EMPTY;
                    end
                end
                TWO: begin
                    // r_ready is low here, so no input can arrive.
                    if (w_out_fire) begin
                        w_state_nxt      = ONE;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            // Registered ready: low exactly while both entries are occupied.
            r_ready <= (w_state_nxt != TWO);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_main_data <= '0;
            r_main_ctrl <= CTRL_NOP;
            r_skid_data <= '0;
            r_skid_ctrl <= CTRL_NOP;
        end else begin
            if (w_main_from_in) begin
                r_main_data <= i_data;
                r_main_ctrl <= i_ctrl;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_skid_from_in) begin
                r_skid_data <= i_data;
                r_skid_ctrl <= i_ctrl;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_state != EMPTY);
    assign o_data  = r_main_data;
    // Empty stage presents a NOP so a stale payload can never act downstream.
    assign o_ctrl  = (r_state == EMPTY) ? CTRL_NOP : r_main_ctrl;

`ifdef PIPE_STAGE_STATS_EN
    logic w_stall, w_flush_drop;

    assign w_stall = o_valid & ~i_ready;
    // A flush "discards" something when the skid entry is lost, the main
    // entry is lost (not delivered this cycle), or an accepted input is lost.
    assign w_flush_drop = i_flush & ((r_state == TWO)
                                   | ((r_state == ONE) & ~i_ready)
                                   | w_in_fire);

    pipe_stat_counter #(.W(STAT_W)) u_stall_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (w_stall),
        .o_cnt     (o_stall_cnt)
    );

    pipe_stat_counter #(.W(STAT_W)) u_flush_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (w_flush_drop),
        .o_cnt     (o_flush_cnt)
    );
`endif

endmodule
